// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_if
//  Description : Signal bundle between the boot host / instruction memory and
//                the program loader.
//                Host side     : start, rx_valid, rx_data -> loader
//                                rx_ready               <- loader
//                Memory side   : we, waddr, wdata       <- loader
//                Status        : core_rst, busy, done, err <- loader
//                Modport master is the host/memory environment; modport slave
//                is the loader itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface imem_loader_if;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start,
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  we,
        input  waddr,
        input  wdata,
        input  core_rst,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  start,
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output we,
        output waddr,
        output wdata,
        output core_rst,
        output busy,
        output done,
        output err
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time program loader. Receives a framed byte stream
//                (16-bit word count N, 4N little-endian data bytes, checksum
//                byte), writes each assembled word into instruction memory and
//                keeps the core in reset until a frame with a good checksum
//                has been loaded.
//  Ports       : clk  - system clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - imem_loader_if.slave (stream in, memory write port,
//                       core_rst / busy / done / err status)
//  Parameters  : ADDR_W - instruction-memory word-address width (<= 16)
//                BASE   - byte address of the first written word
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader #(
    parameter int          ADDR_W = 8,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  wire           clk,
    input  wire           rst,
    imem_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_CSUM  = 3'd5
    } state_t;

    // Largest legal word count is the full memory, 2^ADDR_W words.
    localparam logic [16:0] c_cap = 17'd1 << ADDR_W;

    state_t              r_state;
    state_t              w_state_nx;

    logic [15:0]         r_len;
    logic [ADDR_W:0]     r_word_idx;
    logic [1:0]          r_byte_idx;
    logic [7:0]          r_sum;
    logic [31:0]         r_wdata;
    logic                r_core_rst;
    logic                r_done;
    logic                r_err;

    logic                w_rx_ready;
    logic                w_accept;
    logic                w_start_ok;
    logic [15:0]         w_len_new;
    logic [ADDR_W:0]     w_idx_inc;
    logic                w_word_last;
    logic [7:0]          w_sum_chk;
    logic                w_len_bad;
    logic                w_csum_pass;
    logic                w_csum_fail;

    // ------------------------------------------------------------------
    // Handshake and derived values. rx_ready is decoded from the state
    // register only, so there is no path from rx_valid to rx_ready.
    // ------------------------------------------------------------------
    assign w_rx_ready  = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                         (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_accept    = bus.rx_valid && w_rx_ready;
    assign w_start_ok  = (r_state == S_IDLE) && bus.start;
    assign w_len_new   = {bus.rx_data, r_len[7:0]};
    assign w_idx_inc   = r_word_idx + 1'b1;
    assign w_word_last = (17'(w_idx_inc) == {1'b0, r_len});
    // Checksum byte brings the 8-bit running sum to zero on a good frame.
    assign w_sum_chk   = r_sum + bus.rx_data;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and event decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx  = r_state;
        w_len_bad   = 1'b0;
        w_csum_pass = 1'b0;
        w_csum_fail = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nx = S_LEN0;
                end
            end
            S_LEN0: begin
                if (w_accept) begin
                    w_state_nx = S_LEN1;
                end
            end
            S_LEN1: begin
                if (w_accept) begin
                    if ({1'b0, w_len_new} > c_cap) begin
                        w_len_bad  = 1'b1;
                        w_state_nx = S_IDLE;
                    end else if (w_len_new == 16'd0) begin
                        w_state_nx = S_CSUM;
                    end else begin
                        w_state_nx = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept && (r_byte_idx == 2'd3)) begin
                    w_state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                w_state_nx = w_word_last ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (w_accept) begin
                    w_state_nx = S_IDLE;
                    if (w_sum_chk == 8'h00) begin
                        w_csum_pass = 1'b1;
                    end else begin
                        w_csum_fail = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: length capture, word assembly, counters, running sum
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len      <= 16'd0;
            r_word_idx <= '0;
            r_byte_idx <= 2'd0;
            r_sum      <= 8'd0;
            r_wdata    <= 32'd0;
        end else if (w_start_ok) begin
            // Fresh session: counters and sum restart from zero.
            r_len      <= 16'd0;
            r_word_idx <= '0;
            r_byte_idx <= 2'd0;
            r_sum      <= 8'd0;
        end else begin
            if (w_accept && (r_state == S_LEN0)) begin
                r_len[7:0] <= bus.rx_data;
            end
            if (w_accept && (r_state == S_LEN1)) begin
                r_len[15:8] <= bus.rx_data;
            end
            if (w_accept && (r_state == S_DATA)) begin
                r_wdata[8*r_byte_idx +: 8] <= bus.rx_data;
                r_sum                      <= r_sum + bus.rx_data;
                r_byte_idx                 <= r_byte_idx + 2'd1;
            end
            if (r_state == S_WRITE) begin
                r_word_idx <= w_idx_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= w_csum_pass;
            if (w_start_ok) begin
                // Reloading re-holds the core for the whole session.
                r_core_rst <= 1'b1;
                r_err      <= 1'b0;
            end else if (w_csum_pass) begin
                r_core_rst <= 1'b0;
            end else if (w_len_bad || w_csum_fail) begin
                r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.rx_ready = w_rx_ready;
    assign bus.we       = (r_state == S_WRITE);
    assign bus.waddr    = BASE + (32'(r_word_idx) << 2);
    assign bus.wdata    = r_wdata;
    assign bus.core_rst = r_core_rst;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = r_done;
    assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Directed self-checking bench for imem_loader. Streams
//                hand-built frames and checks writes, done/err, core_rst
//                and timing against hand-computed values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    logic clk;
    logic rst;

    imem_loader_if bus ();

    imem_loader #(
        .ADDR_W (8),
        .BASE   (32'h0000_0000)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_bad;
    int          n_wr;
    int          n_done;
    logic [31:0] wr_addr [0:15];
    logic [31:0] wr_data [0:15];

    // Write / done monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.we) begin
            if (n_wr < 16) begin
                wr_addr[n_wr] = bus.waddr;
                wr_data[n_wr] = bus.wdata;
            end
            n_wr = n_wr + 1;
        end
        if (bus.done) begin
            n_done = n_done + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Presents one byte after 'gap' idle cycles and holds it until accepted.
    // Returns one time unit after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        repeat (gap) tick();
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (bus.rx_ready) ok = 1'b1;
            tick();
        end
        bus.rx_valid = 1'b0;
        if (!ok) chk("rx_accept_timeout", 32'd0, 32'd1);
    endtask

    // Good-load frame: N=2, words 0x00000013 and 0x00500093, checksum 0x0A.
    task automatic send_frame(input logic [7:0] last, input int max_gap, input int n_bytes);
        logic [7:0] s [0:10];
        s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h50, 8'h00, 8'h0A};
        s[10] = last;
        for (int i = 0; i < n_bytes; i++) begin
            send_byte(s[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
    endtask

    task automatic check_good_writes(input string tag);
        chk({tag, "_nwr"},   n_wr, 2);
        chk({tag, "_addr0"}, wr_addr[0], 32'h0000_0000);
        chk({tag, "_data0"}, wr_data[0], 32'h0000_0013);
        chk({tag, "_addr1"}, wr_addr[1], 32'h0000_0004);
        chk({tag, "_data1"}, wr_data[1], 32'h0050_0093);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec = 0; n_bad = 0; n_wr = 0; n_done = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;

        // ---------------- reset ----------------
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_rx_ready", bus.rx_ready, 0);
        chk("rst_we",       bus.we,       0);
        chk("rst_core_rst", bus.core_rst, 1);
        chk("rst_busy",     bus.busy,     0);
        chk("rst_done",     bus.done,     0);
        chk("rst_err",      bus.err,      0);
        chk("rst_waddr",    bus.waddr,    32'h0);
        chk("rst_wdata",    bus.wdata,    32'h0);

        // ---------------- good load ----------------
        n_wr = 0; n_done = 0;
        pulse_start();
        chk("good_ready_after_start", bus.rx_ready, 1);
        chk("good_busy", bus.busy, 1);
        send_frame(8'h0A, 0, 11);
        chk("good_done_pulse", bus.done, 1);
        chk("good_core_rst_low", bus.core_rst, 0);
        chk("good_busy_idle", bus.busy, 0);
        chk("good_err", bus.err, 0);
        repeat (3) tick();
        chk("good_done_once", n_done, 1);
        chk("good_done_fell", bus.done, 0);
        check_good_writes("good");

        // ---------------- bad checksum ----------------
        n_wr = 0; n_done = 0;
        pulse_start();
        chk("bad_core_rst_reheld", bus.core_rst, 1);
        send_frame(8'h0B, 0, 11);
        chk("bad_err", bus.err, 1);
        chk("bad_busy", bus.busy, 0);
        chk("bad_core_rst", bus.core_rst, 1);
        repeat (3) tick();
        chk("bad_no_done", n_done, 0);
        chk("bad_err_sticky", bus.err, 1);
        check_good_writes("bad");

        // ---------------- oversize count ----------------
        n_wr = 0; n_done = 0;
        pulse_start();
        chk("big_err_cleared", bus.err, 0);
        send_byte(8'h2C, 0);
        send_byte(8'h01, 0);
        chk("big_err", bus.err, 1);
        chk("big_rx_ready", bus.rx_ready, 0);
        chk("big_busy", bus.busy, 0);
        repeat (5) tick();
        chk("big_no_we", n_wr, 0);
        chk("big_core_rst", bus.core_rst, 1);

        // ---------------- good load with gaps ----------------
        n_wr = 0; n_done = 0;
        pulse_start();
        send_frame(8'h0A, 5, 11);
        chk("gap_done_pulse", bus.done, 1);
        chk("gap_core_rst", bus.core_rst, 0);
        repeat (3) tick();
        chk("gap_done_once", n_done, 1);
        check_good_writes("gap");

        // ---------------- empty frame ----------------
        n_wr = 0; n_done = 0;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("empty_done_pulse", bus.done, 1);
        chk("empty_core_rst", bus.core_rst, 0);
        repeat (3) tick();
        chk("empty_no_we", n_wr, 0);
        chk("empty_done_once", n_done, 1);

        // ---------------- reset mid-load ----------------
        n_wr = 0; n_done = 0;
        pulse_start();
        send_frame(8'h0A, 0, 7);   // N bytes plus five data bytes
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rx_ready", bus.rx_ready, 0);
        chk("mid_busy", bus.busy, 0);
        chk("mid_core_rst", bus.core_rst, 1);
        chk("mid_we", bus.we, 0);
        chk("mid_wdata", bus.wdata, 32'h0);
        chk("mid_nwr_before", n_wr, 1);
        n_wr = 0; n_done = 0;
        pulse_start();
        send_frame(8'h0A, 0, 11);
        chk("mid_done_pulse", bus.done, 1);
        repeat (3) tick();
        chk("mid_done_once", n_done, 1);
        check_good_writes("mid");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the single-cycle RISC-V core. It receives a framed byte stream over a valid/ready interface and assembles little-endian 32-bit instruction words. Each word is written through the instruction memory's write port. The core is held in reset until a complete frame with a valid checksum has been loaded. It is the writing end of the instruction memory, which the core otherwise only reads.

## Interface
- ADDR_W, 8: instruction-memory word-address width; capacity 2^ADDR_W words.
- BASE, 32'h0000_0000: byte address of the first written word.

- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that begins a load session; honoured only in IDLE.
- rx_valid  in  1  byte available on rx_data.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader accepts the byte; a transfer occurs when rx_valid && rx_ready.
- we  out  1  instruction-memory write enable.
- waddr  out  32  byte address of the write; word-aligned.
- wdata  out  32  assembled instruction word.
- core_rst  out  1  reset to the core; high while no valid program is loaded.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful load.
- err  out  1  sticky error flag; cleared by rst or by an accepted start.

## Operation
- Frame layout, in order:
  - N: 16-bit word count, low byte first.
  - N×4 data bytes, each word little-endian (byte0 = bits 7:0).
  - One checksum byte C.
- Checksum rule: (sum of all 4N data bytes + C) mod 256 == 0. Count bytes are excluded.
- States and transitions:
  - IDLE: rx_ready=0. On start, clear err and go to LEN0.
  - LEN0: rx_ready=1. Capture N[7:0], then go to LEN1.
  - LEN1: rx_ready=1. Capture N[15:8].
    - If N > 2^ADDR_W: set err, go to IDLE.
    - Else if N == 0: go to CSUM.
    - Else: go to DATA.
  - DATA: rx_ready=1. Shift the byte into wdata[8k+7:8k] for k = 0..3 and add it to the 8-bit running sum. After the 4th byte, go to WRITE.
  - WRITE: rx_ready=0, we=1 for exactly one cycle, with waddr = BASE + 4×word_idx. Then word_idx++.
    - If the incremented word_idx == N: go to CSUM.
    - Else: go to DATA.
  - CSUM: rx_ready=1. On the accepted byte:
    - If the checksum passes: pulse done and go to IDLE; core_rst is 0 from the next cycle.
    - Else: set err and go to IDLE; core_rst stays 1.
- On every accepted start, core_rst is driven back to 1 for the whole session (reload re-holds the core).
- Rejected loads (either error) leave memory partially written. The core stays in reset until a later successful load.
- start is ignored while busy. rx_valid is ignored while rx_ready=0.
- word_idx is ADDR_W+1 bits wide, reset each session. Sum and byte index are reset each session.

## Timing
- Reset values: rx_ready=0, we=0, waddr=BASE, wdata=0, core_rst=1, busy=0, done=0, err=0. State is IDLE and all counters are 0.
- All outputs are registered or decoded from registered state only; no combinational path from rx_valid to rx_ready.
- Start to ready: start sampled at edge t gives rx_ready=1 in cycle t+1.
- Write latency: the 4th byte of a word accepted at edge t gives we=1 with valid waddr/wdata in cycle t+1. we is 0 in all other states.
- Peak throughput: 4 bytes per 5 cycles.
- done: high for one cycle, the cycle after the checksum byte is accepted. core_rst falls in that same cycle. busy is 0 in that cycle.
- err: asserts the cycle after the offending byte is accepted, together with busy=0.
- rx_valid gaps of any length stall the FSM in place with no state change.
- rst asserted in any state, including WRITE: at the next edge all outputs take their reset values and no write is issued in the following cycle. Any partial word is discarded.

## Test plan
- Reset: hold rst 3 cycles, then release -> rx_ready=0, we=0, core_rst=1, busy=0, done=0, err=0.
- Good load: start, then stream 02 00 13 00 00 00 93 00 50 00 0A -> two write pulses: waddr=0x0 with wdata=0x00000013, then waddr=0x4 with wdata=0x00500093. Then a done pulse, core_rst=0, err=0.
- Bad checksum: same stream with last byte 0B -> both writes occur, no done, err=1, core_rst=1.
- Oversize count (ADDR_W=8): stream 2C 01 (N=300) -> err=1 the cycle after the second byte, rx_ready=0, no we ever, core_rst=1.
- Backpressure and empty frame: good load with random 0-5 cycle rx_valid gaps -> identical writes and done. Separately, N=0 with stream 00 00 00 -> done, no we.
- Reset mid-load: assert rst after 5 data bytes of the good load, then rerun the good load -> first write at waddr=0x0 with wdata=0x00000013, ending in done.
